multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have ports opcode, func3 and func7, inputs, 7/3/7 bits: fields from the external instruction register; stable from DECODE until the next irWrite.
REQ-004 SHALL have port memReady, input, 1: shared memory port completed the current access this cycle.
REQ-005 SHALL have port brTaken, input, 1: branch comparison true (ALU zero/compare), sampled in EXEC.
REQ-006 SHALL have outputs irWrite, pcWrite, memRead, memWrite, regWrite, ALUSrc, memToReg, PCToReg, aluToPC and iorD, 1 bit each. iorD: memory address source, 0 = PC, 1 = ALU result.
REQ-007 SHALL have port ALUOp, output, 3: 000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR, 101 SLL.
REQ-008 SHALL have ports halted and illegal, outputs, 1 each: sticky status flags.
REQ-009 SHALL have port state, output, 3: current state encoding, for debug.

Function
REQ-010 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to HALT with illegal=1.
REQ-011 FETCH: memRead=1, iorD=0; stay while memReady=0; on memReady=1 assert irWrite=1 and pcWrite=1 (PC+4) in that same cycle, next DECODE.
REQ-012 DECODE: no strobes. Next state: EXEC for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111 and 1100111; HALT for 1111111; HALT with illegal set for any other opcode.
REQ-013 EXEC ALUOp/ALUSrc: R-type decodes func3/func7 (ADD/SUB/MUL/AND/OR/SLL), ALUSrc=0; I-type ADDI/SLLI, ALUSrc=1; LW/SW/JALR ADD, ALUSrc=1; branch SUB, ALUSrc=0.
REQ-014 EXEC, unsupported func3/func7 combination: SHALL go to HALT with illegal=1; no write strobe.
REQ-015 EXEC next state: R/I to WB; LW/SW to MEM; branch to FETCH, with pcWrite=1 only if brTaken=1; JAL/JALR to WB.
REQ-016 MEM: iorD=1; LW drives memRead=1, SW drives memWrite=1; both held until memReady=1. LW then goes to WB, SW to FETCH.
REQ-017 WB: regWrite=1 for exactly one cycle, next FETCH. memToReg=1 for LW. For JAL/JALR: PCToReg=1, pcWrite=1, and aluToPC=1 (JALR only).
REQ-018 HALT: absorbing; all strobes 0; halted=1. Only reset exits.
REQ-019 All strobes SHALL be combinational from state, the opcode/func fields, memReady and brTaken. No strobe SHALL assert outside its listed state.
REQ-020 Latency with memReady tied 1: R/I/SW/JAL/JALR 4 cycles, LW 5, branch 3.

Reset
REQ-021 rst_n=0 SHALL immediately force state FETCH, clear halted, illegal and the MUL counter, and deassert all write strobes, even mid-MEM.
REQ-022 Output values while in reset: memRead=1, iorD=0, every other output 0 (state=0).

Configuration
REQ-023 With MULTICYCLE_MUL_EN defined, R-type MUL SHALL hold EXEC for exactly 4 cycles. A 2-bit counter runs 0..3 and the state advances to WB when the counter reaches 3; ALUOp=010 is held for all 4 cycles.
REQ-024 Without MULTICYCLE_MUL_EN, MUL SHALL take one EXEC cycle like other R-type instructions, and the counter logic SHALL be absent.

Verification
REQ-025 ADD (opcode 0110011, func3 000, func7 0000000), memReady=1: states 0,1,2,4,0; regWrite high only in cycle 4; ALUOp=000.
REQ-026 LW with memReady low for 3 MEM cycles: memRead and iorD held high 3 cycles, then WB with memToReg=1 and regWrite=1.
REQ-027 BEQ with brTaken=0, then brTaken=1: each takes 3 cycles; pcWrite in EXEC only on the second; ALUOp=001.
REQ-028 Opcode 1111111, then opcode 0000000 after reset: first sets halted=1 with illegal=0; second sets halted=1 and illegal=1; state stays 5 for 20 cycles.
REQ-029 rst_n pulsed low during SW in MEM: memWrite drops in the same cycle with no clock edge; state=0 after release.
REQ-030 MUL (func7 0000001) with MULTICYCLE_MUL_EN: EXEC lasts 4 cycles, total 7; without the macro, total 4.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-style control unit: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer driving datapath strobes.
// Optional build macro MULTICYCLE_MUL_EN: R-type MUL holds EXEC for four cycles.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       memReady,
    input  logic       brTaken,
    output logic       irWrite,
    output logic       pcWrite,
    output logic       memRead,
    output logic       memWrite,
    output logic       regWrite,
    output logic       ALUSrc,
    output logic       memToReg,
    output logic       PCToReg,
    output logic       aluToPC,
    output logic       iorD,
    output logic [2:0] ALUOp,
    output logic       halted,
    output logic       illegal,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_HALT = 7'b1111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;

    state_t     state_q, state_d;
    logic       halted_q, illegal_q;
    logic       set_illegal;
    logic       r_ok;
    logic [2:0] r_aluop;

`ifdef MULTICYCLE_MUL_EN
    logic [1:0] mul_cnt_q, mul_cnt_d;
`endif

    // R-type function decode; anything outside this table is an illegal instruction.
    always_comb begin
        r_ok    = 1'b1;
        r_aluop = ALU_ADD;
        case ({func7, func3})
            {7'b0000000, 3'b000}: r_aluop = ALU_ADD;
            {7'b0100000, 3'b000}: r_aluop = ALU_SUB;
            {7'b0000001, 3'b000}: r_aluop = ALU_MUL;
            {7'b0000000, 3'b111}: r_aluop = ALU_AND;
            {7'b0000000, 3'b110}: r_aluop = ALU_OR;
            {7'b0000000, 3'b001}: r_aluop = ALU_SLL;
            default:              r_ok    = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        set_illegal = 1'b0;
        irWrite     = 1'b0;
        pcWrite     = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        regWrite    = 1'b0;
        ALUSrc      = 1'b0;
        memToReg    = 1'b0;
        PCToReg     = 1'b0;
        aluToPC     = 1'b0;
        iorD        = 1'b0;
        ALUOp       = ALU_ADD;
`ifdef MULTICYCLE_MUL_EN
        mul_cnt_d   = mul_cnt_q;
`endif

        case (state_q)
            S_FETCH: begin
                memRead = 1'b1;
                if (memReady) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                case (opcode)
                    OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR: state_d = S_EXEC;
                    OP_HALT: state_d = S_HALT;
                    default: begin
                        state_d     = S_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end

            S_EXEC: begin
                case (opcode)
                    OP_R: begin
                        ALUOp = r_aluop;
                        if (!r_ok) begin
                            state_d     = S_HALT;
                            set_illegal = 1'b1;
                        end else begin
`ifdef MULTICYCLE_MUL_EN
                            if (r_aluop == ALU_MUL && mul_cnt_q != 2'd3) begin
                                mul_cnt_d = mul_cnt_q + 2'd1;
                            end else begin
                                mul_cnt_d = 2'd0;
                                state_d   = S_WB;
                            end
`else
                            state_d = S_WB;
`endif
                        end
                    end
                    OP_I: begin
                        ALUSrc = 1'b1;
                        if (func3 == 3'b000) begin
                            state_d = S_WB;
                        end else if (func3 == 3'b001 && func7 == 7'b0000000) begin
                            ALUOp   = ALU_SLL;
                            state_d = S_WB;
                        end else begin
                            state_d     = S_HALT;
                            set_illegal = 1'b1;
                        end
                    end
                    OP_LW, OP_SW: begin
                        ALUSrc  = 1'b1;
                        state_d = S_MEM;
                    end
                    OP_BR: begin
                        ALUOp   = ALU_SUB;
                        pcWrite = brTaken;
                        state_d = S_FETCH;
                    end
                    OP_JAL: state_d = S_WB;
                    OP_JALR: begin
                        ALUSrc  = 1'b1;
                        state_d = S_WB;
                    end
                    default: begin
                        state_d     = S_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end

            S_MEM: begin
                iorD = 1'b1;
                if (opcode == OP_LW) begin
                    memRead = 1'b1;
                    if (memReady) state_d = S_WB;
                end else if (opcode == OP_SW) begin
                    memWrite = 1'b1;
                    if (memReady) state_d = S_FETCH;
                end else begin
                    state_d     = S_HALT;
                    set_illegal = 1'b1;
                end
            end

            S_WB: begin
                regWrite = 1'b1;
                memToReg = (opcode == OP_LW);
                if (opcode == OP_JAL || opcode == OP_JALR) begin
                    PCToReg = 1'b1;
                    pcWrite = 1'b1;
                    aluToPC = (opcode == OP_JALR);
                end
                state_d = S_FETCH;
            end

            S_HALT: state_d = S_HALT;

            default: begin
                state_d     = S_HALT;
                set_illegal = 1'b1;
            end
        endcase

        // While reset is held the outputs are pinned to the FETCH idle pattern, even if memReady is high.
        if (!rst_n) begin
            irWrite  = 1'b0;
            pcWrite  = 1'b0;
            memRead  = 1'b1;
            memWrite = 1'b0;
            regWrite = 1'b0;
            ALUSrc   = 1'b0;
            memToReg = 1'b0;
            PCToReg  = 1'b0;
            aluToPC  = 1'b0;
            iorD     = 1'b0;
            ALUOp    = ALU_ADD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q   <= state_d;
            halted_q  <= halted_q | (state_d == S_HALT);
            illegal_q <= illegal_q | set_illegal;
        end
    end

`ifdef MULTICYCLE_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mul_cnt_q <= 2'd0;
        else        mul_cnt_q <= mul_cnt_d;
    end
`endif

    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign state   = state_q;

endmodule
